// File: rtl/serial_alu_calc.sv
// Bit-serial XOR/NAND/ADD/SUB unit: one result bit per clock, LSB first, with a
// single carry/borrow flop and valid/ready handshakes on both sides.
module serial_alu_calc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             z,
   output logic             v
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] OP_XOR  = 2'b00;
   localparam logic [1:0] OP_NAND = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_y;
   logic [1:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_cy;
   logic             r_z;
   logic             r_v;

   logic w_ai;
   logic w_bi;
   logic w_ri;
   logic w_cy_next;
   logic w_v_msb;

   // Single-bit slice; w_v_msb is only meaningful on the MSB (last RUN) cycle.
   always_comb begin
      w_ai      = r_a[0];
      w_bi      = r_b[0];
      w_ri      = 1'b0;
      w_cy_next = 1'b0;
      w_v_msb   = 1'b0;
      case (r_op)
         OP_XOR:  w_ri = w_ai ^ w_bi;
         OP_NAND: w_ri = ~(w_ai & w_bi);
         OP_ADD: begin
            w_ri      = w_ai ^ w_bi ^ r_cy;
            w_cy_next = (w_ai & w_bi) | (w_ai & r_cy) | (w_bi & r_cy);
            w_v_msb   = (w_ai & w_bi & ~w_ri) | (~w_ai & ~w_bi & w_ri);
         end
         default: begin
            w_ri      = w_ai ^ w_bi ^ r_cy;
            w_cy_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_cy);
            w_v_msb   = (w_ai & ~w_bi & ~w_ri) | (~w_ai & w_bi & w_ri);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_y     <= '0;
         r_op    <= OP_XOR;
         r_cnt   <= '0;
         r_cy    <= 1'b0;
         r_z     <= 1'b0;
         r_v     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op;
                  r_cnt   <= '0;
                  r_cy    <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_y   <= {w_ri, r_y[WIDTH-1:1]};
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_cy  <= w_cy_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_z     <= r_op[1] ? w_cy_next : 1'b0;
                  r_v     <= r_op[1] ? w_v_msb : 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign y         = r_y;
   assign z         = r_z;
   assign v         = r_v;

endmodule

// File: tb/tb_serial_alu_calc.sv
// Bench for serial_alu_calc: an 8-bit instance for directed/random/backpressure/reset
// cases and a 4-bit instance swept exhaustively against an arithmetic reference model.
module tb_serial_alu_calc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;

   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, z8, v8;
   logic [7:0] a8 = '0, b8 = '0, y8;
   logic [1:0] op8 = '0;

   logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, z4, v4;
   logic [3:0] a4 = '0, b4 = '0, y4;
   logic [1:0] op4 = '0;

   int errors = 0;
   int checks = 0;

   serial_alu_calc #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .y(y8), .z(z8), .v(v8)
   );

   serial_alu_calc #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
      .y(y4), .z(z4), .v(v4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result from plain integer arithmetic: {v, z, y}
   function automatic logic [65:0] model(input int w, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input logic [1:0] opc);
      logic [63:0] mask, ta, tb, ry;
      logic        rz, rv;
      mask = (64'd1 << w) - 64'd1;
      ta = a_in & mask;
      tb = b_in & mask;
      rz = 1'b0;
      rv = 1'b0;
      case (opc)
         2'b00: ry = (ta ^ tb) & mask;
         2'b01: ry = ~(ta & tb) & mask;
         2'b10: begin
            ry = (ta + tb) & mask;
            rz = (ta + tb) > mask;
            rv = (ta[w-1] == tb[w-1]) && (ry[w-1] != ta[w-1]);
         end
         default: begin
            ry = (ta - tb) & mask;
            rz = ta < tb;
            rv = (ta[w-1] != tb[w-1]) && (ry[w-1] != ta[w-1]);
         end
      endcase
      return {rv, rz, ry};
   endfunction

   // Issue one operation, check latency and result; optionally hold DONE for bp cycles.
   task automatic run_op(input bit w4, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [1:0] top, input int bp);
      int          w, n, lat;
      logic [65:0] exp;
      logic [7:0]  hy;
      logic        hz, hv;
      w = w4 ? 4 : 8;
      n = 0;
      while (!(w4 ? in_ready4 : in_ready8) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_idle", 64'(w4 ? in_ready4 : in_ready8), 64'd1);
      if (w4) begin a4 = ta[3:0]; b4 = tb[3:0]; op4 = top; in_valid4 = 1'b1; end
      else    begin a8 = ta;      b8 = tb;      op8 = top; in_valid8 = 1'b1; end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      in_valid8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); op4 = 2'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
      lat = 0;
      while (!(w4 ? out_valid4 : out_valid8) && lat < 3 * w) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", 64'(lat), 64'(w));
      exp = model(w, 64'(ta), 64'(tb), top);
      hy = w4 ? {4'b0, y4} : y8;
      hz = w4 ? z4 : z8;
      hv = w4 ? v4 : v8;
      check("y", 64'(hy), exp[63:0]);
      check("z", 64'(hz), 64'(exp[64]));
      check("v", 64'(hv), 64'(exp[65]));
      check("in_ready_done", 64'(w4 ? in_ready4 : in_ready8), 64'd0);
      $display("W=%0d op=%0d a=%0h b=%0h -> y=%0h z=%0b v=%0b lat=%0d",
               w, top, ta, tb, hy, hz, hv, lat);
      if (bp > 0 && !w4) begin
         out_ready8 = 1'b0;
         for (int k = 0; k < bp; k++) begin
            in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            check("bp_out_valid", 64'(out_valid8), 64'd1);
            check("bp_in_ready", 64'(in_ready8), 64'd0);
            check("bp_y_hold", 64'(y8), 64'(hy));
            check("bp_zv_hold", 64'({z8, v8}), 64'({hz, hv}));
         end
         out_ready8 = 1'b1;
      end
      @(posedge clk); #1;
      check("release_in_ready", 64'(w4 ? in_ready4 : in_ready8), 64'd1);
      check("release_out_valid", 64'(w4 ? out_valid4 : out_valid8), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready8", 64'(in_ready8), 64'd1);
      check("rst_out_valid8", 64'(out_valid8), 64'd0);
      check("rst_yzv8", 64'({y8, z8, v8}), 64'd0);
      check("rst_in_ready4", 64'(in_ready4), 64'd1);
      check("rst_yzv4", 64'({y4, z4, v4, out_valid4}), 64'd0);

      // Directed corner cases
      run_op(1'b0, 8'hFF, 8'h01, 2'b10, 0);
      run_op(1'b0, 8'h7F, 8'h01, 2'b10, 0);
      run_op(1'b0, 8'h80, 8'h01, 2'b11, 0);
      run_op(1'b0, 8'h00, 8'h01, 2'b11, 0);
      run_op(1'b0, 8'hF0, 8'hCC, 2'b01, 0);
      run_op(1'b0, 8'hF0, 8'hCC, 2'b00, 5);

      // Reset after three RUN cycles discards the operation
      a8 = 8'hAB; b8 = 8'hCD; op8 = 2'b10; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrun_rst_in_ready", 64'(in_ready8), 64'd1);
      check("midrun_rst_out_valid", 64'(out_valid8), 64'd0);
      check("midrun_rst_yzv", 64'({y8, z8, v8}), 64'd0);
      run_op(1'b0, 8'h12, 8'h34, 2'b10, 0);

      // Random 8-bit operations
      for (int i = 0; i < 40; i++)
         run_op(1'b0, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 0);

      // Exhaustive 4-bit sweep, back-to-back with out_ready high
      for (int o = 0; o < 4; o++)
         for (int x = 0; x < 16; x++)
            for (int yv = 0; yv < 16; yv++)
               run_op(1'b1, 8'(x), 8'(yv), 2'(o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
